// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment patterns are active-low, ordered a..g from bit 6 down to bit 0.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b0000001;
  localparam seg_t SEG_1   = 7'b1001111;
  localparam seg_t SEG_2   = 7'b0010010;
  localparam seg_t SEG_3   = 7'b0000110;
  localparam seg_t SEG_4   = 7'b1001100;
  localparam seg_t SEG_5   = 7'b0100100;
  localparam seg_t SEG_6   = 7'b0100000;
  localparam seg_t SEG_7   = 7'b0001111;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0000100;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b1100000;
  localparam seg_t SEG_C   = 7'b0110001;
  localparam seg_t SEG_D   = 7'b1000010;
  localparam seg_t SEG_E   = 7'b0110000;
  localparam seg_t SEG_F   = 7'b0111000;
  localparam seg_t SEG_OFF = 7'b1111111;

  function automatic seg_t seg_decode(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
    return seg;
  endfunction

  function automatic bit params_legal(input int num_digits, input int refresh_div,
                                      input int deadtime);
    return (num_digits >= 1) && (num_digits <= 8) && (refresh_div >= 2) &&
           (deadtime >= 0) && (deadtime < refresh_div);
  endfunction

endpackage

// File: rtl/deco_hex_7seg.sv
// Hex nibble to active-low 7-segment pattern, with a blanking override.
module deco_hex_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_OFF : seg_decode(i_nibble);
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed N-digit common-anode 7-segment driver with dead time,
// leading-zero suppression and frame-synchronous (tear-free) value updates.
module display_mux_7seg
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEADTIME    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lz_en,
  input  logic                    i_enable,
  output logic [6:0]              o_segmentos,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_anodos,
  output logic                    o_frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEADTIME);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (!params_legal(NUM_DIGITS, REFRESH_DIV, DEADTIME)) begin : g_bad_params
    $error("display_mux_7seg: illegal NUM_DIGITS/REFRESH_DIV/DEADTIME combination");
  end

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anodos_q, anodos_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic                  seg_blank;
  seg_t                  seg_dec;
  logic                  slot_end;
  logic                  frame_end;

  // A digit is suppressed when it and every digit to its left are zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib[k] = disp_val_q[4*k +: 4];
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (nib[k] == 4'h0);
      lz_blank[k] = zero_run;
    end
  end

  always_comb begin
    nib_sel   = nib[idx_q];
    seg_blank = !i_enable || (i_lz_en && lz_blank[idx_q]);
  end

  deco_hex_7seg u_deco (
    .i_nibble (nib_sel),
    .i_blank  (seg_blank),
    .o_seg    (seg_dec)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    slot_end  = (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    if (i_load) begin
      pend_val_d = i_value;
      pend_dp_d  = i_dp;
    end

    // Taking the next pending value lets a load on the wrap cycle show at once.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (frame_end) begin
      disp_val_d = pend_val_d;
      disp_dp_d  = pend_dp_d;
    end

    seg_d    = seg_dec;
    dp_d     = !(i_enable && disp_dp_q[idx_q]);
    anodos_d = '1;
    if (i_enable && (presc_q >= DEAD_END)) begin
      anodos_d[idx_q] = 1'b0;
    end
    frame_done_d = frame_end;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      anodos_q     <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anodos_q     <= anodos_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_segmentos  = seg_q;
  assign o_dp         = dp_q;
  assign o_anodos     = anodos_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Self-checking bench for display_mux_7seg: directed scenarios followed by
// random traffic, all compared against a cycle-count based reference model.
module tb_display_mux_7seg;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    dp;
  logic          lz;
  logic          en;
  logic [6:0]    o_segmentos;
  logic          o_dp;
  logic [3:0]    o_anodos;
  logic          o_frame_done;

  display_mux_7seg #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .DEADTIME    (DEAD)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_value      (value),
    .i_load       (load),
    .i_dp         (dp),
    .i_lz_en      (lz),
    .i_enable     (en),
    .o_segmentos  (o_segmentos),
    .o_dp         (o_dp),
    .o_anodos     (o_anodos),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: the scan position is a pure function of cycles since reset.
  int          cyc;
  logic [15:0] m_pend, m_shown;
  logic [3:0]  m_pend_dp, m_shown_dp;
  int          fd_count;
  int          fd_start;
  int          n_checks;
  int          n_fail;

  task automatic step(input string tag);
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;
    logic [15:0] upper;
    int          presc, idx;
    bit          wrap;
    if (rst) begin
      e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111; e_fd = 1'b0;
      cyc = 0; m_pend = '0; m_shown = '0; m_pend_dp = '0; m_shown_dp = '0;
    end else begin
      presc = cyc % DIV;
      idx   = (cyc / DIV) % ND;
      wrap  = (presc == DIV - 1) && (idx == ND - 1);
      upper = m_shown >> (4 * idx);
      e_seg = (!en || (lz && idx != 0 && upper == 16'h0)) ? 7'b1111111 : glyph[upper[3:0]];
      e_dp  = !(en && m_shown_dp[idx]);
      e_an  = 4'b1111;
      if (en && presc >= DEAD) e_an[idx] = 1'b0;
      e_fd  = wrap;
      if (load) begin m_pend = value; m_pend_dp = dp; end
      if (wrap) begin m_shown = m_pend; m_shown_dp = m_pend_dp; end
      cyc++;
    end
    @(posedge clk);
    #1;
    if (o_frame_done) fd_count++;
    n_checks++;
    assert (o_segmentos === e_seg) else begin
      n_fail++; $error("FAIL %s seg: got %b expected %b (cyc %0d)", tag, o_segmentos, e_seg, cyc);
    end
    n_checks++;
    assert (o_dp === e_dp) else begin
      n_fail++; $error("FAIL %s dp: got %b expected %b (cyc %0d)", tag, o_dp, e_dp, cyc);
    end
    n_checks++;
    assert (o_anodos === e_an) else begin
      n_fail++; $error("FAIL %s anodes: got %b expected %b (cyc %0d)", tag, o_anodos, e_an, cyc);
    end
    n_checks++;
    assert (o_frame_done === e_fd) else begin
      n_fail++; $error("FAIL %s frame_done: got %b expected %b (cyc %0d)", tag, o_frame_done, e_fd, cyc);
    end
  endtask

  task automatic goto_phase(input int ph, input string tag);
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != ph; i++) step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; dp = '0; lz = 1'b0; en = 1'b1;
    cyc = 0; m_pend = '0; m_shown = '0; m_pend_dp = '0; m_shown_dp = '0;
    fd_count = 0; n_checks = 0; n_fail = 0;

    repeat (3) step("reset");
    rst = 1'b0;

    // Basic scan of 0x12AF, dp on digit 1.
    value = 16'h12AF; dp = 4'b0010; load = 1'b1;
    step("basic_load");
    load = 1'b0;
    fd_start = fd_count;
    repeat (47) step("basic_scan");
    n_checks++;
    assert (fd_count - fd_start == 3) else begin
      n_fail++; $error("FAIL basic_pulses: got %0d expected 3", fd_count - fd_start);
    end
    goto_phase(6, "basic_scan");
    step("basic_digit1");
    n_checks++;
    assert (o_anodos === 4'b1101 && o_segmentos === 7'b0001000 && o_dp === 1'b0) else begin
      n_fail++; $error("FAIL basic_digit1: got an=%b seg=%b dp=%b expected 1101/0001000/0",
                       o_anodos, o_segmentos, o_dp);
    end

    // Leading-zero suppression.
    lz = 1'b1; value = 16'h0050; load = 1'b1;
    step("lz_load");
    load = 1'b0;
    repeat (2 * FRAME) step("lz_0050");
    goto_phase(13, "lz_0050");
    step("lz_digit3");
    n_checks++;
    assert (o_anodos === 4'b0111 && o_segmentos === 7'b1111111) else begin
      n_fail++; $error("FAIL lz_digit3: got an=%b seg=%b expected 0111/1111111", o_anodos, o_segmentos);
    end
    value = 16'h0000; load = 1'b1;
    step("lz_load0");
    load = 1'b0;
    repeat (2 * FRAME) step("lz_0000");
    goto_phase(1, "lz_0000");
    step("lz_digit0");
    n_checks++;
    assert (o_anodos === 4'b1110 && o_segmentos === 7'b0000001) else begin
      n_fail++; $error("FAIL lz_digit0: got an=%b seg=%b expected 1110/0000001", o_anodos, o_segmentos);
    end

    // Tear-free loads.
    lz = 1'b0;
    goto_phase(5, "tear");
    value = 16'hBEEF; load = 1'b1;
    step("tear_mid_load");
    load = 1'b0;
    goto_phase(10, "tear_old");
    step("tear_old_digit2");
    n_checks++;
    assert (o_segmentos === 7'b0000001) else begin
      n_fail++; $error("FAIL tear_old_digit2: got %b expected 0000001", o_segmentos);
    end
    repeat (FRAME) step("tear_beef");
    goto_phase(15, "tear");
    value = 16'h1234; load = 1'b1;
    step("wrap_load");
    load = 1'b0;
    step("wrap_new");
    n_checks++;
    assert (o_segmentos === 7'b1001100) else begin
      n_fail++; $error("FAIL wrap_new: got %b expected 1001100", o_segmentos);
    end

    // Display disabled across a wrap.
    goto_phase(12, "enable");
    fd_start = fd_count;
    en = 1'b0;
    repeat (8) step("enable_off");
    en = 1'b1;
    n_checks++;
    assert (fd_count - fd_start == 1) else begin
      n_fail++; $error("FAIL enable_pulses: got %0d expected 1", fd_count - fd_start);
    end

    // Reset in the middle of digit 2.
    goto_phase(9, "rst_mid");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    step("rst_restart0");
    step("rst_restart1");
    n_checks++;
    assert (o_anodos === 4'b1110) else begin
      n_fail++; $error("FAIL rst_restart: got %b expected 1110", o_anodos);
    end

    // Random traffic.
    repeat (600) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      dp    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lz = ~lz;
      if ($urandom_range(0, 31) == 0) en = ~en;
      rst   = ($urandom_range(0, 249) == 0);
      step("random");
    end
    rst = 1'b0; load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux_7seg.md
Name: display_mux_7seg

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It holds a hex value of 4*NUM_DIGITS bits and decodes one digit at a time to active-low segments, scanning the digits at a programmable refresh rate. Features:
- Decimal points.
- Leading-zero suppression.
- Anti-ghosting dead time at each digit switch.
- Tear-free updates: a new value is applied only at a frame boundary.

It sits between the datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; range 1..8
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2
DEADTIME, 16, cycles at the start of each slot during which all anodes are off; 0 <= DEADTIME < REFRESH_DIV

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_value  in  4*NUM_DIGITS  hex value; nibble k drives digit k; digit 0 is the rightmost digit
i_load  in  1  one-cycle strobe; captures i_value and i_dp into the pending register
i_dp  in  NUM_DIGITS  decimal point request per digit; 1 = lit
i_lz_en  in  1  1 = suppress leading zeros
i_enable  in  1  0 = display dark; counters keep running
o_segmentos  out  7  segments, bit6=a ... bit0=g, active-low
o_dp  out  1  decimal point, active-low
o_anodos  out  NUM_DIGITS  digit select, active-low, one-hot-low
o_frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous and active-high.
- Reset values:
  - Prescaler = 0, digit index = 0.
  - Pending and display registers = 0, dp registers = 0.
  - o_segmentos = 7'b1111111, o_dp = 1, o_anodos = all 1, o_frame_done = 0.
  - Asserting i_rst mid-frame yields exactly these values on the next edge.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
- Digit index advances when the prescaler equals REFRESH_DIV-1. It wraps from NUM_DIGITS-1 to 0.
- On the index wrap edge:
  - display register <= pending register;
  - o_frame_done = 1 for that one cycle.
- Simultaneous events:
  - i_load on the wrap cycle: i_value/i_dp go straight into both the pending and display registers.
  - i_load at any other time updates pending only; the visible digits must not change mid-frame.
- Outputs are registered: one cycle of latency from (index, prescaler, display register) to the pins.
- Anode selection:
  - During a slot whose prescaler value is < DEADTIME: o_anodos = all 1, and segments and dp are still driven.
  - Otherwise: o_anodos[index] = 0, all other anodes = 1.
- Decode (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression (i_lz_en=1):
  - Digit k is blank (segments 1111111) if it and every higher digit are 0.
  - Digit 0 is never suppressed.
  - o_dp is unaffected by suppression.
- i_enable=0: o_anodos = all 1, o_segmentos = 1111111, o_dp = 1. Prescaler, index and o_frame_done continue.
- o_dp = ~dp_display[index].

Decomposition:
- Package display_pkg holds:
  - segment constants SEG_0..SEG_F and SEG_OFF;
  - a decode function nibble -> 7-bit pattern;
  - the parameter legality checks.
- One combinational sub-module, deco_hex_7seg: 4-bit nibble plus blank input -> 7-bit active-low pattern. The top instantiates it once on the muxed nibble.

Test Plan:
Test parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEADTIME=1.
- Reset check: hold i_rst for 3 cycles -> o_segmentos=1111111, o_anodos=1111, o_dp=1, o_frame_done=0.
- Basic scan: load 0x12AF with i_dp=0010, run 2 frames -> per slot, cycle 0 has anodes 1111; cycles 1-3 show:
  - anodes 1110, seg 0111000 (F), dp 1;
  - anodes 1101, seg 0001000 (A), dp 0;
  - anodes 1011, seg 0010010 (2), dp 1;
  - anodes 0111, seg 1001111 (1), dp 1;
  - o_frame_done pulses once every 16 cycles.
- Leading-zero suppression, i_lz_en=1:
  - 0x0050 -> digits 3 and 2 show 1111111, digit 1 shows 0100100, digit 0 shows 0000001.
  - 0x0000 -> only digit 0 shows 0000001.
- Tear-free load: i_load 0xBEEF mid-frame -> old value persists until the wrap. i_load on the wrap cycle -> the new value is visible in the same frame.
- Enable: i_enable=0 for 8 cycles -> anodes stay 1111 while o_frame_done still pulses on schedule.
- Reset mid-frame: i_rst at index 2 -> next edge gives reset values, and the scan restarts at digit 0.
